// File: rtl/nand_vector_sequencer.sv
// Clocked stimulus/check harness for a two-input NAND network: walks a/b through
// 00,01,10,11, holds each vector HOLD cycles, samples c at window end and tallies mismatches.
module nand_vector_sequencer #(
    parameter int unsigned HOLD = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       c,
    output logic       a,
    output logic       b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [1:0] first_fail,
    output logic [1:0] vec_idx
);

    localparam int unsigned CNT_W = (HOLD + 1 > 2) ? $clog2(HOLD + 1) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       vec_q, vec_d;
    logic             a_q, a_d;
    logic             b_q, b_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [2:0]       err_q, err_d;
    logic [1:0]       ff_q, ff_d;
    logic             win_end_c;
    logic             mismatch_c;

    assign win_end_c  = (cnt_q == CNT_W'(HOLD - 1));
    // The network should produce ~(a&b); equality with a&b is therefore a miss.
    assign mismatch_c = (c == (a_q & b_q));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        vec_d   = vec_q;
        a_d     = a_q;
        b_d     = b_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;
        err_d   = err_q;
        ff_d    = ff_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                    vec_d   = 2'd0;
                    a_d     = 1'b0;
                    b_d     = 1'b0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    err_d   = 3'd0;
                    ff_d    = 2'd0;
                end
            end
            S_RUN: begin
                if (win_end_c) begin
                    if (mismatch_c) begin
                        err_d = err_q + 3'd1;
                        if (err_q == 3'd0) begin
                            ff_d = vec_q;
                        end
                    end
                    if (vec_q == 2'd3) begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (err_d == 3'd0);
                    end else begin
                        vec_d = vec_q + 2'd1;
                        cnt_d = '0;
                        a_d   = vec_d[1];
                        b_d   = vec_d[0];
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            vec_q   <= 2'd0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= 3'd0;
            ff_q    <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vec_q   <= vec_d;
            a_q     <= a_d;
            b_q     <= b_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            ff_q    <= ff_d;
        end
    end

    assign a          = a_q;
    assign b          = b_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_count  = err_q;
    assign first_fail = ff_q;
    assign vec_idx    = vec_q;

endmodule

// File: doc/nand_vector_sequencer.md
# nand_vector_sequencer

Synchronous stimulus-and-check stage that sits directly upstream and downstream of the two-input NAND network `rete1`. It drives the network's `a`/`b` inputs through all four input combinations, holding each for a fixed number of clock cycles. It samples the network's output `c` at the end of each hold window and compares it against the expected NAND value. Mismatches are counted and a pass/fail verdict is reported, so that delay-based hand-written benches can be replaced by a clocked, self-checking harness.

## Interface
Parameters:
- `HOLD`, 4, clock cycles each input vector is held; legal range 1..255.

Ports:
- `clock`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  single-cycle request to begin a run; sampled on a rising edge.
- `c`  in  1  output of the network under test.
- `a`  out  1  registered drive for the network's first input.
- `b`  out  1  registered drive for the network's second input.
- `busy`  out  1  high while a run is in progress.
- `done`  out  1  high from the end of a run until the next accepted `start` or `reset`.
- `pass`  out  1  equals `done` AND (`err_count` == 0).
- `err_count`  out  3  number of mismatching vectors in the current or last run (0..4).
- `first_fail`  out  2  vector index of the first mismatch; valid only when `err_count` != 0.
- `vec_idx`  out  2  index of the vector currently being driven.

## Operation
- One clock domain. `reset` is asynchronous and active-high, and is the only asynchronous input.
- The reset value of every output is 0. The FSM resets to IDLE and the hold counter resets to 0.
- FSM states: IDLE, RUN, DONE.
  - IDLE: when `start`=1, load `vec_idx`=0, hold counter=0, `err_count`=0 and `first_fail`=0; set `busy`=1; go to RUN.
  - RUN: drive `a`=`vec_idx`[1] and `b`=`vec_idx`[0]. The vector order is 00, 01, 10, 11. The hold counter increments every cycle.
  - End of window (hold counter == HOLD-1):
    - Sample `c` and compare it with ~(`a`&`b`).
    - On mismatch, increment `err_count`. If this is the first mismatch of the run, also load `first_fail`=`vec_idx`.
    - If `vec_idx`==3: go to DONE with `busy`=0 and `done`=1.
    - Otherwise: increment `vec_idx` and clear the hold counter.
  - DONE: `a`, `b` and `vec_idx` hold their last values. `err_count` and `first_fail` are frozen. `start`=1 behaves exactly as it does in IDLE, including clearing `done`.
- `start` is ignored while in RUN and has no side effects.
- `err_count` cannot exceed 4, so no saturation logic is required.
- Hold counter width is ceil(log2(HOLD+1)). For HOLD=1 the end-of-window condition is true on every RUN cycle.
- Reset asserted during RUN aborts the run immediately. All outputs return to 0, `done` is not asserted, and the partial error count is discarded.

## Timing
- Let `start` be sampled at edge T. Then `busy`=1, `a`=`b`=0 and `vec_idx`=0 after edge T.
- Vector k (k=0..3) is driven from edge T+k*HOLD until edge T+(k+1)*HOLD.
- `c` is sampled at edge T+(k+1)*HOLD. This gives the network HOLD-1 full cycles plus one period of settling.
- At edge T+4*HOLD: `busy`=0, `done`=1, and `err_count`, `first_fail` and `pass` are final in the same cycle.
- A mismatch detected at edge T+(k+1)*HOLD is visible on `err_count` immediately after that edge.
- The earliest restart is a `start` in the first DONE cycle. It is accepted with no dead cycles.
- `busy` and `done` are never high at the same time.

## Test plan
- Correct NAND connected, HOLD=4, `start` at edge 2:
  - `a`/`b` follow 00, 01, 10, 11 at edges 2, 6, 10 and 14.
  - At edge 18: `done`=1, `pass`=1, `err_count`=0.
- AND network connected (c = a&b): `err_count`=4, `first_fail`=0, `pass`=0.
- `c` tied to 1: `err_count`=1, `first_fail`=3, `pass`=0.
- `start` pulsed again at T+5, during RUN: no effect. The run still ends at T+16 with the same results as an undisturbed run.
- Reset asserted mid-cycle at T+6 (asynchronous):
  - All outputs read 0 before the next edge and FSM is IDLE.
  - A fresh `start` then completes normally.
- HOLD=1, correct NAND: the run completes at T+4 with `pass`=1. A `start` in the DONE cycle clears `done` and restarts with `err_count`=0.
